tjmono2_rx_merge: RTL and testbench

//  Merges NCH per-lane RX data streams (first-word-fall-through FIFO outputs of the lane receivers)

---
 rtl/tjmono2_rx_merge_if.sv | 17 +
 rtl/tjmono2_rx_merge.sv | 141 ++++++++++++++
 tb/tb_tjmono2_rx_merge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tjmono2_rx_merge_if.sv
// tjmono2_rx_merge_if
//  Output FIFO stream of the RX lane merger toward the readout arbiter.
//  Signals:
//   FIFO_READ   pop strobe from the consumer
//   FIFO_EMPTY  buffer empty flag
//   FIFO_DATA   head word (first-word-fall-through), valid while FIFO_EMPTY=0
//   FIFO_SIZE   buffer occupancy in words
//  Modports: master = merger (producer side), slave = downstream consumer.
interface tjmono2_rx_merge_if;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [15:0] FIFO_SIZE;

    modport master (input FIFO_READ, output FIFO_EMPTY, FIFO_DATA, FIFO_SIZE);
    modport slave  (output FIFO_READ, input FIFO_EMPTY, FIFO_DATA, FIFO_SIZE);
endinterface

// File: rtl/tjmono2_rx_merge.sv
// tjmono2_rx_merge
//  Merges NCH first-word-fall-through lane FIFOs into a single 32-bit word
//  stream. Enabled, non-empty lanes are served round-robin; each word carries
//  its lane index. Words are buffered in a FIFO_DEPTH-word output FIFO.
//  Word: {DATA_IDENTIFIER, TYPE, CH[2:0], PAYLOAD[23:0]}; TYPE=1 is a
//  timestamp word with CH=7.
//  Ports:
//   BUS_CLK, BUS_RST     clock, asynchronous active-high reset
//   CH_EN, CH_EMPTY      lane enable mask, lane empty flags
//   CH_DATA              lane payloads, lane i at [i*DW +: DW]
//   CH_READ              one-hot lane pop strobe (combinational)
//   TS_TRIG, TIMESTAMP   timestamp request pulse and value
//   fifo                 output stream (see tjmono2_rx_merge_if)
//   WORD_CNT             words written into the buffer, wrapping
//   TS_LOST_CNT          dropped timestamp requests, saturating
//  Build option: define TJMONO2_RX_MERGE_TS_EN to enable the timestamp path;
//  without it TS_TRIG/TIMESTAMP are ignored and TS_LOST_CNT stays 0.
module tjmono2_rx_merge #(
    parameter logic [3:0] DATA_IDENTIFIER = 4'h0,
    parameter int         NCH             = 4,
    parameter int         DW              = 24,
    parameter int         FIFO_DEPTH      = 16
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [NCH-1:0]      CH_EN,
    input  logic [NCH-1:0]      CH_EMPTY,
    input  logic [NCH*DW-1:0]   CH_DATA,
    output logic [NCH-1:0]      CH_READ,
    input  logic                TS_TRIG,
    input  logic [23:0]         TIMESTAMP,
    tjmono2_rx_merge_if.master  fifo,
    output logic [15:0]         WORD_CNT,
    output logic [7:0]          TS_LOST_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [RW-1:0] rr;
    logic [RW-1:0] grant_idx;
    logic          grant_vld;
    logic          space, lane_wr, ts_wr, wr_en, rd_en;
    logic          ts_pending;
    logic [23:0]   ts_data;
    logic [23:0]   payload;
    logic [31:0]   wr_word;
    int            idx;

    // No lookahead on a same-cycle read: space comes from registered count only.
    assign space = (count < (AW+1)'(FIFO_DEPTH));

    // Round-robin search starting at rr; walking downwards makes the lowest
    // offset from rr the final (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(rr) + k) % NCH;
            if (CH_EN[idx] && !CH_EMPTY[idx]) begin
                grant_vld = 1'b1;
                grant_idx = RW'(idx);
            end
        end
    end

    always_comb begin
        payload         = '0;
        payload[DW-1:0] = CH_DATA[int'(grant_idx)*DW +: DW];
    end

    // A pending timestamp takes the write slot ahead of every lane.
    assign lane_wr = space && !ts_pending && grant_vld;
    assign CH_READ = (lane_wr && !BUS_RST) ? (NCH'(1) << grant_idx) : '0;
    assign wr_en   = ts_wr || lane_wr;
    assign rd_en   = fifo.FIFO_READ && (count != '0);
    assign wr_word = ts_wr ? {DATA_IDENTIFIER, 1'b1, 3'b111, ts_data}
                           : {DATA_IDENTIFIER, 1'b0, 3'(grant_idx), payload};

`ifdef TJMONO2_RX_MERGE_TS_EN
    assign ts_wr = space && ts_pending;

    // A trigger in the cycle the pending word is written re-arms rather than drops.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            ts_pending  <= 1'b0;
            ts_data     <= '0;
            TS_LOST_CNT <= '0;
        end else if (TS_TRIG) begin
            if (!ts_pending || ts_wr) begin
                ts_pending <= 1'b1;
                ts_data    <= TIMESTAMP;
            end else if (TS_LOST_CNT != 8'hFF) begin
                TS_LOST_CNT <= TS_LOST_CNT + 8'd1;
            end
        end else if (ts_wr) begin
            ts_pending <= 1'b0;
        end
    end
`else
    logic unused_ts;
    assign unused_ts   = ^{TS_TRIG, TIMESTAMP};
    assign ts_wr       = 1'b0;
    assign ts_pending  = 1'b0;
    assign ts_data     = '0;
    assign TS_LOST_CNT = 8'd0;
`endif

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr       <= '0;
            WORD_CNT <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + AW'(1);
                WORD_CNT <= WORD_CNT + 16'd1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
            if (lane_wr)
                rr <= (grant_idx == RW'(NCH - 1)) ? '0 : grant_idx + RW'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge BUS_CLK) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    assign fifo.FIFO_EMPTY = (count == '0);
    assign fifo.FIFO_DATA  = (count == '0) ? 32'h0 : mem[rd_ptr];
    assign fifo.FIFO_SIZE  = 16'(count);
endmodule

// File: tb/tb_tjmono2_rx_merge.sv
module tb_tjmono2_rx_merge;
    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
`ifdef TJMONO2_RX_MERGE_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST;
    logic [NCH-1:0]    CH_EN, CH_EMPTY, CH_READ;
    logic [NCH*DW-1:0] CH_DATA;
    logic              TS_TRIG;
    logic [23:0]       TIMESTAMP;
    logic [15:0]       WORD_CNT;
    logic [7:0]        TS_LOST_CNT;

    tjmono2_rx_merge_if fifo ();

    tjmono2_rx_merge #(
        .DATA_IDENTIFIER (4'h5),
        .NCH             (NCH),
        .DW              (DW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .CH_EN       (CH_EN),
        .CH_EMPTY    (CH_EMPTY),
        .CH_DATA     (CH_DATA),
        .CH_READ     (CH_READ),
        .TS_TRIG     (TS_TRIG),
        .TIMESTAMP   (TIMESTAMP),
        .fifo        (fifo),
        .WORD_CNT    (WORD_CNT),
        .TS_LOST_CNT (TS_LOST_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] lq [NCH][$];
    bit use_q = 1'b0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  empty;
        logic        rd;
        logic [3:0]  exp_read;
        int          exp_size;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tv [12];

    function automatic logic [31:0] w(int ch, logic [15:0] d);
        return {4'h5, 1'b0, 3'(ch), 8'h00, d};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; drives lanes from the queue model, records the
    // pop strobe the DUT presents before the rising edge, returns at next fall.
    task automatic cyc(output logic [NCH-1:0] rd_seen);
        if (use_q)
            for (int i = 0; i < NCH; i++) begin
                CH_EMPTY[i] = (lq[i].size() == 0);
                CH_DATA[i*DW +: DW] = (lq[i].size() != 0) ? lq[i][0] : '0;
            end
        #1;
        rd_seen = CH_READ;
        @(posedge BUS_CLK);
        if (use_q)
            for (int i = 0; i < NCH; i++)
                if (rd_seen[i] && lq[i].size() != 0) void'(lq[i].pop_front());
        @(negedge BUS_CLK);
    endtask

    task automatic do_reset();
        BUS_RST = 1'b1;
        for (int i = 0; i < NCH; i++) lq[i].delete();
        CH_EMPTY = '1;
        fifo.FIFO_READ = 1'b0;
        TS_TRIG = 1'b0;
        @(negedge BUS_CLK);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
    endtask

    task automatic load(logic [15:0] base, int nw);
        for (int i = 0; i < NCH; i++)
            for (int k = 0; k < nw; k++)
                lq[i].push_back(16'(base + i * 256 + k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NCH-1:0] r;
        BUS_RST = 1'b1;
        CH_EN = '0;
        CH_EMPTY = '1;
        CH_DATA = '0;
        TS_TRIG = 1'b0;
        TIMESTAMP = '0;
        fifo.FIFO_READ = 1'b0;

        // Reset state
        @(negedge BUS_CLK);
        chk("rst_empty", fifo.FIFO_EMPTY, 1);
        chk("rst_size", fifo.FIFO_SIZE, 0);
        chk("rst_data", fifo.FIFO_DATA, 0);
        chk("rst_ch_read", CH_READ, 0);
        chk("rst_wcnt", WORD_CNT, 0);
        chk("rst_lost", TS_LOST_CNT, 0);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;

        // Table: lane i holds constant 0xC00i; rows run back to back from reset.
        tv[0]  = '{4'hF, 4'hF, 1'b0, 4'h0, 0, 32'h0};
        tv[1]  = '{4'hF, 4'h0, 1'b0, 4'h1, 1, w(0, 16'hC000)};
        tv[2]  = '{4'hF, 4'h0, 1'b0, 4'h2, 2, w(0, 16'hC000)};
        tv[3]  = '{4'h5, 4'h0, 1'b0, 4'h4, 3, w(0, 16'hC000)};
        tv[4]  = '{4'h5, 4'h0, 1'b0, 4'h1, 4, w(0, 16'hC000)};
        tv[5]  = '{4'h5, 4'h0, 1'b0, 4'h4, 5, w(0, 16'hC000)};
        tv[6]  = '{4'hF, 4'h8, 1'b0, 4'h1, 6, w(0, 16'hC000)};
        tv[7]  = '{4'hF, 4'h2, 1'b0, 4'h4, 7, w(0, 16'hC000)};
        tv[8]  = '{4'h0, 4'h0, 1'b0, 4'h0, 7, w(0, 16'hC000)};
        tv[9]  = '{4'hF, 4'h0, 1'b1, 4'h8, 7, w(1, 16'hC001)};
        tv[10] = '{4'hF, 4'hF, 1'b1, 4'h0, 6, w(2, 16'hC002)};
        tv[11] = '{4'h8, 4'h7, 1'b0, 4'h8, 7, w(2, 16'hC002)};
        use_q = 1'b0;
        for (int i = 0; i < NCH; i++) CH_DATA[i*DW +: DW] = 16'(16'hC000 + i);
        for (int v = 0; v < 12; v++) begin
            CH_EN = tv[v].en;
            CH_EMPTY = tv[v].empty;
            fifo.FIFO_READ = tv[v].rd;
            #1;
            chk($sformatf("vec%0d_ch_read", v), CH_READ, tv[v].exp_read);
            @(posedge BUS_CLK);
            @(negedge BUS_CLK);
            chk($sformatf("vec%0d_size", v), fifo.FIFO_SIZE, tv[v].exp_size);
            chk($sformatf("vec%0d_data", v), fifo.FIFO_DATA, tv[v].exp_data);
            chk($sformatf("vec%0d_empty", v), fifo.FIFO_EMPTY, tv[v].exp_size == 0);
        end
        fifo.FIFO_READ = 1'b0;
        chk("vec_wcnt", WORD_CNT, 9);

        // Round-robin order: 4 lanes x 3 words
        do_reset();
        use_q = 1'b1;
        CH_EN = '1;
        load(16'h1000, 3);
        for (int c = 0; c < 14; c++) cyc(r);
        chk("order_size", fifo.FIFO_SIZE, 12);
        chk("order_wcnt", WORD_CNT, 12);
        fifo.FIFO_READ = 1'b1;
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("order_w%0d", n), fifo.FIFO_DATA,
                w(n % 4, 16'(16'h1000 + (n % 4) * 256 + n / 4)));
            cyc(r);
        end
        fifo.FIFO_READ = 1'b0;
        chk("order_drained", fifo.FIFO_EMPTY, 1);

        // Full buffer back-pressure
        do_reset();
        use_q = 1'b1;
        CH_EN = '1;
        load(16'h2000, 6);
        for (int c = 0; c < 20; c++) cyc(r);
        chk("full_size", fifo.FIFO_SIZE, 16);
        cyc(r);
        chk("full_no_read", r, 0);
        fifo.FIFO_READ = 1'b1;
        cyc(r);
        chk("full_rd_no_lookahead", r, 0);
        chk("full_after_rd", fifo.FIFO_SIZE, 15);
        fifo.FIFO_READ = 1'b0;
        cyc(r);
        chk("full_refill", r, 4'b0001);
        chk("full_refilled", fifo.FIFO_SIZE, 16);

        // Timestamp requests while full: first latched, two dropped
        for (int t = 0; t < 3; t++) begin
            TS_TRIG = 1'b1;
            TIMESTAMP = (t == 0) ? 24'hABCDEF : 24'(24'h111111 * t);
            cyc(r);
        end
        TS_TRIG = 1'b0;
        chk("ts_lost", TS_LOST_CNT, TS_ON ? 2 : 0);
        fifo.FIFO_READ = 1'b1;
        cyc(r);
        fifo.FIFO_READ = 1'b0;
        TS_TRIG = 1'b1;
        TIMESTAMP = 24'h333333;
        cyc(r);
        TS_TRIG = 1'b0;
        chk("ts_slot_ch_read", r, TS_ON ? 4'b0000 : 4'b0010);
        chk("ts_retrig_lost", TS_LOST_CNT, TS_ON ? 2 : 0);
        fifo.FIFO_READ = 1'b1;
        for (int c = 0; c < 15; c++) cyc(r);
        chk("ts_word1", fifo.FIFO_DATA, TS_ON ? 32'h5FABCDEF : w(1, 16'h2104));
        cyc(r);
        chk("ts_word2", fifo.FIFO_DATA, TS_ON ? 32'h5F333333 : w(2, 16'h2204));
        fifo.FIFO_READ = 1'b0;

        // Reset asserted with 10 words buffered
        do_reset();
        use_q = 1'b1;
        CH_EN = '1;
        load(16'h3000, 3);
        for (int c = 0; c < 10; c++) cyc(r);
        chk("mid_size", fifo.FIFO_SIZE, 10);
        BUS_RST = 1'b1;
        #1;
        chk("mid_rst_empty", fifo.FIFO_EMPTY, 1);
        chk("mid_rst_size", fifo.FIFO_SIZE, 0);
        chk("mid_rst_data", fifo.FIFO_DATA, 0);
        chk("mid_rst_ch_read", CH_READ, 0);
        @(posedge BUS_CLK);
        #1;
        chk("mid_rst_ch_read_edge", CH_READ, 0);
        chk("mid_rst_wcnt", WORD_CNT, 0);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        cyc(r);
        chk("post_rst_grant", r, 4'b0100);
        chk("post_rst_size", fifo.FIFO_SIZE, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
